// File: rtl/kbd_scancode_decoder.sv
// rtl/kbd_scancode_decoder.sv - PS/2 keyboard scancode decoder with event FIFO; optional macro KBD_PARITY_CHECK_EN enables odd-parity checking
module kbd_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [9:0] event_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       overflow_o,
    output logic       frame_err_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;

    // synchronizer and edge detector state
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall_edge;
    logic       ps2_data;

    // frame receiver state
    state_t          state;
    state_t          state_nxt;
    logic [3:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [TW-1:0]   to_cnt;
    logic            timeout_hit;
    logic            parity_ok;
    logic            frame_ok_d;
    logic            frame_bad_d;
    logic            timeout_d;
    logic            byte_strb;

    // decoder state
    logic            ext_flag;
    logic            brk_flag;
    logic            emit_valid;
    logic [9:0]      emit_data;

    // event FIFO state
    logic [9:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            pop;
    logic            push_ok;

    // Two-flop synchronizers plus one history flop for the PS/2 clock; idle-high reset avoids a false edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall_edge   = clk_prev & ~clk_sync[1];
    assign ps2_data    = data_sync[1];
    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef KBD_PARITY_CHECK_EN
    assign parity_ok = ^{shreg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // Frame FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next state: start bit opens a frame, stop edge or idle timeout closes it
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fall_edge && !ps2_data) begin
                    state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (fall_edge && bit_cnt == 4'd9) begin
                    state_nxt = S_IDLE;
                end else if (!fall_edge && timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame FSM outputs: verdict on the stop edge and timeout detection
    always_comb begin
        frame_ok_d  = 1'b0;
        frame_bad_d = 1'b0;
        timeout_d   = 1'b0;
        if (state == S_RECV) begin
            if (fall_edge && bit_cnt == 4'd9) begin
                frame_ok_d  = ps2_data && parity_ok;
                frame_bad_d = !(ps2_data && parity_ok);
            end else if (!fall_edge && timeout_hit) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Bit shifter, bit counter and idle timer; verdicts are registered into one-cycle strobes
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bit_cnt     <= 4'd0;
            shreg       <= 8'd0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            byte_strb   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            byte_strb   <= frame_ok_d;
            frame_err_o <= frame_bad_d | timeout_d;
            if (state == S_IDLE) begin
                bit_cnt <= 4'd0;
                to_cnt  <= '0;
            end else if (fall_edge) begin
                to_cnt  <= '0;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt < 4'd8) begin
                    shreg <= {ps2_data, shreg[7:1]};
                end
                if (bit_cnt == 4'd8) begin
                    par_bit <= ps2_data;
                end
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Prefix decoder: E0/F0 only arm flags, any other byte emits an event and consumes them
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            emit_valid <= 1'b0;
            emit_data  <= 10'd0;
        end else begin
            emit_valid <= 1'b0;
            if (frame_err_o) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_strb) begin
                case (shreg)
                    8'hE0:   ext_flag <= 1'b1;
                    8'hF0:   brk_flag <= 1'b1;
                    default: begin
                        emit_valid <= 1'b1;
                        emit_data  <= {shreg, ext_flag, brk_flag};
                        ext_flag   <= 1'b0;
                        brk_flag   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign full    = (count == CW'(FIFO_DEPTH));
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign push_ok = emit_valid && (!full || pop);
    assign event_o = valid_o ? mem[rd_ptr] : 10'd0;

    // FIFO storage; no reset needed because the output is gated by valid_o
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= emit_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow on a dropped push
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (emit_valid && full && !pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// tb/tb_kbd_scancode_decoder.sv - self-checking bench for kbd_scancode_decoder
module tb_kbd_scancode_decoder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50000;
    localparam int HALF    = 6;

    logic       clk;
    logic       reset_i;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic [9:0] event_o;
    logic       valid_o;
    logic       ready_i;
    logic       overflow_o;
    logic       frame_err_o;

    kbd_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .event_o     (event_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .overflow_o  (overflow_o),
        .frame_err_o (frame_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       flip_par;
        logic       stop;
        logic       emit;
        logic [9:0] ev;
        logic       err;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         errors = 0;
    int         checks = 0;

    int         err_pulses = 0;
    int         wide_err   = 0;
    int         hold_bad   = 0;
    logic       err_prev   = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [9:0] prev_ev    = 10'd0;

    // Observe transfers, hold stability and frame-error pulse width away from the active edge
    always @(negedge clk) begin
        if (!reset_i && valid_o && ready_i) got_q.push_back(event_o);
        if (!reset_i && prev_valid && !prev_ready && valid_o && event_o != prev_ev) hold_bad++;
        if (err_prev && frame_err_o) wide_err++;
        if (frame_err_o) err_pulses++;
        err_prev   = frame_err_o;
        prev_valid = valid_o && !reset_i;
        prev_ready = ready_i;
        prev_ev    = event_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_events(input string tag);
        logic [9:0] g;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                check({tag, " unexpected event"}, {22'd0, g}, 32'hFFFF_FFFF);
            end else begin
                check({tag, " event"}, {22'd0, g}, {22'd0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_bit);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data_i = bits[i];
            tick(HALF);
            ps2_clk_i = 1'b0;
            tick(HALF);
            ps2_clk_i = 1'b1;
        end
        tick(HALF);
    endtask

    task automatic send_partial(input logic [7:0] b, input int ndata);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i <= ndata; i++) begin
            ps2_data_i = bits[i];
            tick(HALF);
            ps2_clk_i = 1'b0;
            tick(HALF);
            ps2_clk_i = 1'b1;
        end
        tick(HALF);
    endtask

    initial begin
        int e0;
        int waited;

        reset_i    = 1'b1;
        ps2_clk_i  = 1'b1;
        ps2_data_i = 1'b1;
        ready_i    = 1'b1;

        tbl.push_back('{8'h1C, 1'b0, 1'b1, 1'b1, {8'h1C, 2'b00}, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 1'b1, 1'b0, 10'd0,          1'b0});
        tbl.push_back('{8'hF0, 1'b0, 1'b1, 1'b0, 10'd0,          1'b0});
        tbl.push_back('{8'h74, 1'b0, 1'b1, 1'b1, {8'h74, 2'b11}, 1'b0});
        tbl.push_back('{8'h1C, 1'b0, 1'b1, 1'b1, {8'h1C, 2'b00}, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 1'b1, 1'b0, 10'd0,          1'b0});
        tbl.push_back('{8'h12, 1'b0, 1'b1, 1'b1, {8'h12, 2'b10}, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 1'b1, 1'b0, 10'd0,          1'b0});
        tbl.push_back('{8'h12, 1'b0, 1'b1, 1'b1, {8'h12, 2'b01}, 1'b0});
        tbl.push_back('{8'hAA, 1'b0, 1'b1, 1'b1, {8'hAA, 2'b00}, 1'b0});
        tbl.push_back('{8'hFA, 1'b0, 1'b1, 1'b1, {8'hFA, 2'b00}, 1'b0});
        tbl.push_back('{8'hE1, 1'b0, 1'b1, 1'b1, {8'hE1, 2'b00}, 1'b0});
`ifdef KBD_PARITY_CHECK_EN
        tbl.push_back('{8'h1C, 1'b1, 1'b1, 1'b0, 10'd0,          1'b1});
`else
        tbl.push_back('{8'h1C, 1'b1, 1'b1, 1'b1, {8'h1C, 2'b00}, 1'b0});
`endif
        tbl.push_back('{8'hF0, 1'b0, 1'b1, 1'b0, 10'd0,          1'b0});
        tbl.push_back('{8'h1C, 1'b0, 1'b0, 1'b0, 10'd0,          1'b1});
        tbl.push_back('{8'h1C, 1'b0, 1'b1, 1'b1, {8'h1C, 2'b00}, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 1'b1, 1'b0, 10'd0,          1'b0});
        tbl.push_back('{8'h74, 1'b0, 1'b0, 1'b0, 10'd0,          1'b1});
        tbl.push_back('{8'h74, 1'b0, 1'b1, 1'b1, {8'h74, 2'b00}, 1'b0});

        // reset state
        tick(3);
        check("reset valid_o", {31'd0, valid_o}, 32'd0);
        check("reset event_o", {22'd0, event_o}, 32'd0);
        check("reset overflow_o", {31'd0, overflow_o}, 32'd0);
        check("reset frame_err_o", {31'd0, frame_err_o}, 32'd0);
        reset_i = 1'b0;
        tick(4);

        // table-driven frames with ready held high
        for (int i = 0; i < tbl.size(); i++) begin
            e0 = err_pulses;
            if (tbl[i].emit) exp_q.push_back(tbl[i].ev);
            send_frame(tbl[i].b, tbl[i].flip_par, tbl[i].stop);
            tick(8);
            compare_events($sformatf("row%0d", i));
            check($sformatf("row%0d frame_err count", i), 32'(err_pulses - e0), {31'd0, tbl[i].err});
        end

        // valid_o holds with a stable event until the consumer accepts it
        ready_i = 1'b0;
        exp_q.push_back({8'h1C, 2'b00});
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(10);
        check("held valid_o", {31'd0, valid_o}, 32'd1);
        check("held event_o", {22'd0, event_o}, {22'd0, 8'h1C, 2'b00});
        tick(20);
        check("still held valid_o", {31'd0, valid_o}, 32'd1);
        ready_i = 1'b1;
        tick(3);
        compare_events("held");
        check("drained valid_o", {31'd0, valid_o}, 32'd0);

        // FIFO overflow: five events into a four-entry FIFO with no consumer
        ready_i = 1'b0;
        exp_q.push_back({8'h15, 2'b00});
        exp_q.push_back({8'h16, 2'b00});
        exp_q.push_back({8'h1D, 2'b00});
        exp_q.push_back({8'h24, 2'b00});
        send_frame(8'h15, 1'b0, 1'b1);
        send_frame(8'h16, 1'b0, 1'b1);
        send_frame(8'h1D, 1'b0, 1'b1);
        send_frame(8'h24, 1'b0, 1'b1);
        tick(8);
        check("full no overflow yet", {31'd0, overflow_o}, 32'd0);
        send_frame(8'h2D, 1'b0, 1'b1);
        tick(8);
        check("overflow_o set", {31'd0, overflow_o}, 32'd1);
        check("full head event", {22'd0, event_o}, {22'd0, 8'h15, 2'b00});
        ready_i = 1'b1;
        tick(10);
        compare_events("drain");
        check("drain queue empty", 32'(exp_q.size()), 32'd0);
        check("empty valid_o", {31'd0, valid_o}, 32'd0);
        check("overflow sticky", {31'd0, overflow_o}, 32'd1);

        // mid-frame timeout
        e0 = err_pulses;
        send_partial(8'h1C, 4);
        waited = 0;
        while (err_pulses == e0 && waited < TIMEOUT + 100) begin
            tick(1);
            waited++;
        end
        check("timeout frame_err count", 32'(err_pulses - e0), 32'd1);
        check("timeout latency in window",
              {31'd0, (waited >= TIMEOUT - 20 && waited <= TIMEOUT + 5)}, 32'd1);
        tick(4);
        exp_q.push_back({8'h1C, 2'b00});
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(8);
        compare_events("after timeout");

        // asynchronous reset mid-frame with an undelivered event pending
        ready_i = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(8);
        check("pre-reset valid_o", {31'd0, valid_o}, 32'd1);
        send_partial(8'h29, 5);
        ps2_data_i = 1'b1;
        #3;
        reset_i = 1'b1;
        #1;
        check("async reset valid_o", {31'd0, valid_o}, 32'd0);
        check("async reset event_o", {22'd0, event_o}, 32'd0);
        check("async reset overflow_o", {31'd0, overflow_o}, 32'd0);
        check("async reset frame_err_o", {31'd0, frame_err_o}, 32'd0);
        tick(3);
        reset_i = 1'b0;
        tick(4);
        ready_i = 1'b1;
        exp_q.push_back({8'h29, 2'b00});
        send_frame(8'h29, 1'b0, 1'b1);
        tick(8);
        compare_events("after reset");

        check("expected queue drained", 32'(exp_q.size()), 32'd0);
        check("event hold stability violations", 32'(hold_bad), 32'd0);
        check("frame_err pulse longer than one cycle", 32'(wide_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
